// File: rtl/blink_countdown_timer.sv
// ---------------------------------------------------------------------------
// blink_countdown_timer
//
// Purpose:
//   Countdown timer that drives one status LED. A prescaler turns the system
//   clock into a one-second tick. Each tick decrements a loadable seconds
//   counter toward zero. While the remaining time is above a programmable
//   split point, the LED blinks with a fixed duty cycle ("slow phase"). At or
//   below the split point, it toggles on every tick ("fast phase"). The block
//   also supports start/restart, pause, abort, runtime load and optional
//   auto-reload at expiry.
//
// Ports:
//   Clock_50    in   1       system clock
//   Resetn      in   1       asynchronous active-low reset
//   Start       in   1       single-cycle start/restart request
//   Pause       in   1       level; high freezes a running countdown
//   Abort       in   1       single-cycle; return to IDLE
//   Load_en     in   1       single-cycle; capture Load_val as reload value
//   Load_val    in   TIME_W  seconds to load (0 selects DEFAULT_TIME)
//   Split       in   TIME_W  slow/fast phase boundary
//   LED         out  1       registered LED drive
//   Remaining   out  TIME_W  registered seconds remaining
//   Fast_phase  out  1       registered; 1 when Remaining <= Split
//   Running     out  1       registered; 1 while counting or paused
//   Done        out  1       registered single-cycle expiry pulse
// ---------------------------------------------------------------------------
module blink_countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned CNT_W         = 26,
  parameter int unsigned TIME_W        = 8,
  parameter int unsigned DEFAULT_TIME  = 100,
  parameter int unsigned SLOW_PERIOD   = 10,
  parameter int unsigned SLOW_ON       = 5,
  parameter bit          AUTO_RELOAD   = 1'b0
) (
  input  logic              Clock_50,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Pause,
  input  logic              Abort,
  input  logic              Load_en,
  input  logic [TIME_W-1:0] Load_val,
  input  logic [TIME_W-1:0] Split,
  output logic              LED,
  output logic [TIME_W-1:0] Remaining,
  output logic              Fast_phase,
  output logic              Running,
  output logic              Done
);

  localparam int unsigned BLINK_W = (SLOW_PERIOD > 1) ? $clog2(SLOW_PERIOD) : 1;

  localparam logic [CNT_W-1:0]   PRESC_MAX   = CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [TIME_W-1:0]  DEFAULT_T   = TIME_W'(DEFAULT_TIME);
  localparam logic [TIME_W-1:0]  ONE_SEC     = TIME_W'(1);
  localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(SLOW_PERIOD - 1);
  localparam logic [BLINK_W-1:0] BLINK_ON    = BLINK_W'(SLOW_ON);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [TIME_W-1:0]  remaining, remaining_nxt;
  logic [TIME_W-1:0]  reload_val, reload_nxt;
  logic [CNT_W-1:0]   prescaler, prescaler_nxt;
  logic [BLINK_W-1:0] blink_cnt, blink_nxt;
  logic               led, led_nxt;
  logic               done, done_nxt;
  logic               fast_phase, fast_nxt;
  logic               running, running_nxt;

  // A zero load would expire immediately and look like a stuck timer, so it
  // falls back to the default time instead.
  logic [TIME_W-1:0]  load_eff;
  // Value a Start in IDLE/DONE counts from; it includes a same-cycle load.
  logic [TIME_W-1:0]  start_val;

  assign load_eff = (Load_val == '0) ? DEFAULT_T : Load_val;

  // State register and all registered outputs. Reset drives the timer to an
  // idle, fully reloaded condition without waiting for a clock edge.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state      <= S_IDLE;
      remaining  <= DEFAULT_T;
      reload_val <= DEFAULT_T;
      prescaler  <= PRESC_MAX;
      blink_cnt  <= '0;
      led        <= 1'b0;
      done       <= 1'b0;
      fast_phase <= 1'b0;
      running    <= 1'b0;
    end else begin
      state      <= state_nxt;
      remaining  <= remaining_nxt;
      reload_val <= reload_nxt;
      prescaler  <= prescaler_nxt;
      blink_cnt  <= blink_nxt;
      led        <= led_nxt;
      done       <= done_nxt;
      fast_phase <= fast_nxt;
      running    <= running_nxt;
    end
  end

  // Next-state logic. Control priority is Abort, then Start, then Pause, and
  // only then the tick. Everything holds its value unless a branch changes it.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    reload_nxt    = reload_val;
    prescaler_nxt = prescaler;
    blink_nxt     = blink_cnt;
    led_nxt       = led;
    done_nxt      = 1'b0;
    start_val     = reload_val;

    if (Abort) begin
      state_nxt     = S_IDLE;
      remaining_nxt = reload_val;
      prescaler_nxt = PRESC_MAX;
      blink_nxt     = '0;
      led_nxt       = 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (Load_en) begin
            reload_nxt    = load_eff;
            remaining_nxt = load_eff;
            start_val     = load_eff;
          end
          // The LED keeps its value until the first tick of the new run.
          if (Start) begin
            state_nxt     = S_RUN;
            remaining_nxt = start_val;
            prescaler_nxt = PRESC_MAX;
            blink_nxt     = '0;
          end
        end

        S_RUN, S_HOLD: begin
          if (state == S_RUN && Start) begin
            remaining_nxt = reload_val;
            prescaler_nxt = PRESC_MAX;
            blink_nxt     = '0;
          end else if (Pause) begin
            // Freeze everything. A tick due in this cycle is left pending
            // with the prescaler parked at zero.
            state_nxt = S_HOLD;
          end else begin
            // The cycle that leaves HOLD already counts. A pending tick
            // therefore fires on the resume edge.
            state_nxt = S_RUN;
            if (prescaler != '0) begin
              prescaler_nxt = prescaler - CNT_W'(1);
            end else begin
              prescaler_nxt = PRESC_MAX;

              if (remaining > Split) begin
                led_nxt   = (blink_cnt < BLINK_ON);
                blink_nxt = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BLINK_W'(1);
              end else begin
                led_nxt = ~led;
              end

              // The expiry check also catches zero, so the count can never
              // wrap even if the timer is entered with nothing left.
              if (remaining <= ONE_SEC) begin
                done_nxt = 1'b1;
                if (AUTO_RELOAD) begin
                  remaining_nxt = reload_val;
                  blink_nxt     = '0;
                end else begin
                  remaining_nxt = '0;
                  state_nxt     = S_DONE;
                  led_nxt       = 1'b0;
                end
              end else begin
                remaining_nxt = remaining - ONE_SEC;
              end
            end
          end
        end

        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end

    // Status flags are derived from the values being registered. This keeps
    // them aligned with Remaining and the state in the same cycle.
    fast_nxt    = (remaining_nxt <= Split);
    running_nxt = (state_nxt == S_RUN) || (state_nxt == S_HOLD);
  end

  assign LED        = led;
  assign Remaining  = remaining;
  assign Fast_phase = fast_phase;
  assign Running    = running;
  assign Done       = done;

endmodule

// File: tb/tb_blink_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_blink_countdown_timer
//
// Scoreboard bench for blink_countdown_timer. It runs two instances with
// TICKS_PER_SEC=4: one stops at expiry and one auto-reloads. The stimulus
// process queues hand-computed expected outputs, each tagged with the cycle
// number where it must appear. A separate monitor pops the queue on every
// falling edge and compares the queued values against the selected instance.
// ---------------------------------------------------------------------------
module tb_blink_countdown_timer;

  localparam int TW = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          pause;
  logic          abort;
  logic          load_en;
  logic [TW-1:0] load_val;
  logic [TW-1:0] split;

  logic          led0, fast0, run0, done0;
  logic [TW-1:0] rem0;
  logic          led1, fast1, run1, done1;
  logic [TW-1:0] rem1;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int        at;
    int        dut;
    string     tag;
    logic      led;
    logic [TW-1:0] rem;
    logic      fast;
    logic      run;
    logic      done;
    bit        chk_led;
  } exp_t;

  exp_t sb[$];
  bit   led_tab [12];

  blink_countdown_timer #(
    .TICKS_PER_SEC(4), .CNT_W(3), .TIME_W(TW), .DEFAULT_TIME(100),
    .SLOW_PERIOD(10), .SLOW_ON(5), .AUTO_RELOAD(1'b0)
  ) u_dut_single (
    .Clock_50(clk), .Resetn(rst_n), .Start(start), .Pause(pause),
    .Abort(abort), .Load_en(load_en), .Load_val(load_val), .Split(split),
    .LED(led0), .Remaining(rem0), .Fast_phase(fast0), .Running(run0),
    .Done(done0)
  );

  blink_countdown_timer #(
    .TICKS_PER_SEC(4), .CNT_W(3), .TIME_W(TW), .DEFAULT_TIME(100),
    .SLOW_PERIOD(10), .SLOW_ON(5), .AUTO_RELOAD(1'b1)
  ) u_dut_auto (
    .Clock_50(clk), .Resetn(rst_n), .Start(start), .Pause(pause),
    .Abort(abort), .Load_en(load_en), .Load_val(load_val), .Split(split),
    .LED(led1), .Remaining(rem1), .Fast_phase(fast1), .Running(run1),
    .Done(done1)
  );

  // 10-unit clock period. cyc counts rising edges seen so far.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: cycle=%0d, required finish before timeout", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to the falling edge at which cyc == n.
  task automatic go(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Drive one-cycle control pulses at the current falling edge, then release.
  task automatic applyStimulus(input logic s, input logic a, input logic le,
                               input logic [TW-1:0] lv);
    start    = s;
    abort    = a;
    load_en  = le;
    load_val = lv;
    @(negedge clk);
    start   = 1'b0;
    abort   = 1'b0;
    load_en = 1'b0;
  endtask

  // Queue the outputs expected at the falling edge where cyc == at.
  task automatic checkOutput(input int at, input int dut, input string tag,
                             input logic led, input int rem, input logic fast,
                             input logic run, input logic done, input bit chk_led);
    exp_t e;
    e.at      = at;
    e.dut     = dut;
    e.tag     = tag;
    e.led     = led;
    e.rem     = TW'(rem);
    e.fast    = fast;
    e.run     = run;
    e.done    = done;
    e.chk_led = chk_led;
    sb.push_back(e);
  endtask

  // Monitor: compare every queued expectation that has come due.
  always @(negedge clk) begin : monitor
    exp_t          e;
    logic          a_led, a_fast, a_run, a_done;
    logic [TW-1:0] a_rem;
    bit            ok;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.dut == 0) begin
        a_led = led0; a_rem = rem0; a_fast = fast0; a_run = run0; a_done = done0;
      end else begin
        a_led = led1; a_rem = rem1; a_fast = fast1; a_run = run1; a_done = done1;
      end
      ok = (e.at == cyc) && (a_rem == e.rem) && (a_fast == e.fast) &&
           (a_run == e.run) && (a_done == e.done) &&
           (!e.chk_led || a_led == e.led);
      if (!ok) begin
        n_errors++;
        $display("[TB] FAIL %s cyc=%0d dut=%0d: got led=%0b rem=%0d fast=%0b run=%0b done=%0b, want led=%0b(chk=%0b) rem=%0d fast=%0b run=%0b done=%0b at cyc %0d",
                 e.tag, cyc, e.dut, a_led, a_rem, a_fast, a_run, a_done,
                 e.led, e.chk_led, e.rem, e.fast, e.run, e.done, e.at);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    abort    = 1'b0;
    load_en  = 1'b0;
    load_val = '0;
    split    = 8'd4;
    led_tab  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset state and release.
    checkOutput(3, 0, "reset_values", 1'b0, 100, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(6, 0, "idle_after_reset", 1'b0, 100, 1'b0, 1'b0, 1'b0, 1'b1);
    go(4);
    rst_n = 1'b1;

    // Reset asserted between clock edges while running.
    checkOutput(9,  0, "start_default", 1'b0, 100, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput(13, 0, "tick1_default", 1'b1, 99,  1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput(14, 0, "async_reset",   1'b0, 100, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(18, 0, "idle_post_rst", 1'b0, 100, 1'b0, 1'b0, 1'b0, 1'b1);
    go(8);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    go(13);
    @(posedge clk);
    #1 rst_n = 1'b0;
    go(15);
    rst_n = 1'b1;

    // Full countdown from 12 with split at 4.
    checkOutput(21, 0, "load12", 1'b0, 12, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(23, 0, "start12", 1'b0, 12, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput(26, 0, "pre_tick1", 1'b0, 12, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      checkOutput(23 + 4 * i, 0, "countdown", led_tab[i-1], 12 - i,
                  (12 - i) <= 4, i < 12, i == 12, 1'b1);
    end
    checkOutput(72, 0, "done_one_cycle", 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    go(20);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd12);
    go(22);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);

    // Pause at Remaining=8, prescaler=2, then a second pause and abort.
    checkOutput(76,  0, "restart_from_done", 1'b0, 12, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput(92,  0, "tick4", 1'b1, 8, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput(97,  0, "hold_frozen", 1'b1, 8, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput(102, 0, "resume_no_tick", 1'b1, 8, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput(103, 0, "resume_tick5", 1'b1, 7, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput(107, 0, "tick6", 1'b0, 6, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput(111, 0, "tick7", 1'b0, 5, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput(114, 0, "hold_at5", 1'b0, 5, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput(116, 0, "abort_in_hold", 1'b0, 12, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(119, 0, "idle_no_done", 1'b0, 12, 1'b0, 1'b0, 1'b0, 1'b1);
    go(75);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    go(93);
    pause = 1'b1;
    go(100);
    pause = 1'b0;
    go(112);
    pause = 1'b1;
    go(115);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    pause = 1'b0;

    // Zero load falls back to the default; Start with Abort stays idle.
    checkOutput(121, 0, "load_zero", 1'b0, 100, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(125, 0, "start100", 1'b0, 100, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput(129, 0, "tick1_100", 1'b1, 99, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput(131, 0, "start_abort", 1'b0, 100, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(135, 0, "still_idle", 1'b0, 100, 1'b0, 1'b0, 1'b0, 1'b1);
    go(120);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd0);
    go(124);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    go(130);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);

    // Load+Start of 2 (all fast), then Load+Start of 7 from DONE.
    checkOutput(139, 0, "ldstart2", 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput(143, 0, "fast_toggle", 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput(147, 0, "expire2", 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput(148, 0, "done_state", 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput(151, 0, "ldstart7_done", 1'b0, 7, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput(155, 0, "tick1_7", 1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput(157, 0, "load_in_run_ignored", 1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput(159, 0, "abort_reload7", 1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b1);
    go(138);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd2);
    go(150);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd7);
    go(156);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd50);
    go(158);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);

    // Auto-reload instance counting 3,2,1,3,2,1.
    checkOutput(171, 1, "auto_load3", 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput(173, 1, "auto_start", 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput(177, 1, "auto_t1", 1'b1, 2, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput(181, 1, "auto_t2", 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput(185, 1, "auto_expire1", 1'b0, 3, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput(186, 1, "auto_done_pulse", 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput(189, 1, "auto_t4", 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput(193, 1, "auto_t5", 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput(197, 1, "auto_expire2", 1'b0, 3, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput(198, 1, "auto_still_run", 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0);
    go(165);
    rst_n = 1'b0;
    go(167);
    rst_n = 1'b1;
    go(170);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd3);
    go(172);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    go(200);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    go(205);

    if (sb.size() != 0) begin
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
      n_checks += sb.size();
      n_errors += sb.size();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
